// File: rtl/valid_rx.sv
// Stretched-valid frame receiver: turns a valid window into start/done pulses and checks the beat count.
// Define VALID_RX_SUM_EN to build the frame data accumulator; otherwise o_sum is tied to zero.
module valid_rx #(
  parameter int FRAME_LEN = 1000,
  parameter int DW        = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                i_valid,
  input  logic [DW-1:0]                       i_data,
  output logic                                o_start,
  output logic                                o_done,
  output logic                                o_len_err,
  output logic [$clog2(FRAME_LEN+2)-1:0]      o_beat_cnt,
  output logic [DW+$clog2(FRAME_LEN)-1:0]     o_sum,
  output logic                                o_busy
);

  // state   | meaning
  // IDLE    | no frame in progress, outputs hold last frame's results
  // ACTIVE  | counting beats, cnt <= FRAME_LEN
  // OVERRUN | more than FRAME_LEN beats seen, cnt saturated at FRAME_LEN+1

  localparam int CW = $clog2(FRAME_LEN+2);
  localparam int SW = DW + $clog2(FRAME_LEN);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_OVR  = CW'(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_OVERRUN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d;
  logic          done_q, done_d;
  logic          len_err_q, len_err_d;
  logic          busy_q, busy_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      start_q   <= 1'b0;
      done_q    <= 1'b0;
      len_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      start_q   <= start_d;
      done_q    <= done_d;
      len_err_q <= len_err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_d   = 1'b0;
    done_d    = 1'b0;
    len_err_d = len_err_q;
    case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          state_d = S_ACTIVE;
          cnt_d   = CW'(1);
          start_d = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (i_valid) begin
          if (cnt_q == CNT_FULL) begin
            state_d = S_OVERRUN;
            cnt_d   = CNT_OVR;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          len_err_d = (cnt_q != CNT_FULL);
        end
      end
      S_OVERRUN: begin
        // count stays saturated until the window closes
        if (!i_valid) begin
          state_d   = S_IDLE;
          done_d    = 1'b1;
          len_err_d = (cnt_q != CNT_FULL);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign o_start    = start_q;
  assign o_done     = done_q;
  assign o_len_err  = len_err_q;
  assign o_beat_cnt = cnt_q;
  assign o_busy     = busy_q;

`ifdef VALID_RX_SUM_EN
  logic [SW-1:0] sum_q, sum_d;
  logic          sum_load, sum_add;

  // accumulator enables mirror the FSM's load and in-range increment decisions
  always_comb begin
    sum_load = (state_q == S_IDLE) && i_valid;
    sum_add  = (state_q == S_ACTIVE) && i_valid && (cnt_q != CNT_FULL);
    sum_d    = sum_q;
    if (sum_load) begin
      sum_d = SW'(i_data);
    end else if (sum_add) begin
      sum_d = sum_q + SW'(i_data);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;
`else
  logic unused_data;
  assign unused_data = ^i_data;
  assign o_sum       = '0;
`endif

endmodule

// File: tb/tb_valid_rx.sv
// Directed bench for valid_rx at FRAME_LEN=8, DW=8; sum expectations follow VALID_RX_SUM_EN.
module tb_valid_rx;

  localparam int FRAME_LEN = 8;
  localparam int DW        = 8;
  localparam int CW        = $clog2(FRAME_LEN+2);
  localparam int SW        = DW + $clog2(FRAME_LEN);
`ifdef VALID_RX_SUM_EN
  localparam bit SUM_EN = 1'b1;
`else
  localparam bit SUM_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          i_valid;
  logic [DW-1:0] i_data;
  logic          o_start;
  logic          o_done;
  logic          o_len_err;
  logic [CW-1:0] o_beat_cnt;
  logic [SW-1:0] o_sum;
  logic          o_busy;

  int n_tests;
  int n_fail;

  valid_rx #(.FRAME_LEN(FRAME_LEN), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_valid    (i_valid),
    .i_data     (i_data),
    .o_start    (o_start),
    .o_done     (o_done),
    .o_len_err  (o_len_err),
    .o_beat_cnt (o_beat_cnt),
    .o_sum      (o_sum),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs are set before calling; returns 1 time unit after the edge that samples them
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int esum(input int s);
    return SUM_EN ? s : 0;
  endfunction

  task automatic drive(input logic v, input int d);
    i_valid = v;
    i_data  = DW'(d);
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    i_valid = 1'b1;
    i_data  = 8'h55;
    tick();
    tick();
    check_val("rst_start", int'(o_start), 0);
    check_val("rst_done", int'(o_done), 0);
    check_val("rst_len_err", int'(o_len_err), 0);
    check_val("rst_cnt", int'(o_beat_cnt), 0);
    check_val("rst_sum", int'(o_sum), 0);
    check_val("rst_busy", int'(o_busy), 0);
    reset = 1'b0;
    drive(1'b0, 0);
    check_val("idle_busy", int'(o_busy), 0);

    // short frame: 5 x 0xFF
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'hFF);
      if (i == 1) check_val("short_start", int'(o_start), 1);
    end
    check_val("short_cnt_live", int'(o_beat_cnt), 5);
    drive(1'b0, 0);
    check_val("short_done", int'(o_done), 1);
    check_val("short_len_err", int'(o_len_err), 1);
    check_val("short_cnt", int'(o_beat_cnt), 5);
    check_val("short_sum", int'(o_sum), esum(1275));
    check_val("short_busy", int'(o_busy), 0);
    drive(1'b0, 0);
    check_val("short_done_pulse", int'(o_done), 0);
    check_val("short_len_err_hold", int'(o_len_err), 1);
    check_val("short_cnt_hold", int'(o_beat_cnt), 5);

    // exact frame: data 1..8
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, i);
      if (i == 1) begin
        check_val("exact_start", int'(o_start), 1);
        check_val("exact_cnt1", int'(o_beat_cnt), 1);
        check_val("exact_sum1", int'(o_sum), esum(1));
        check_val("exact_busy", int'(o_busy), 1);
      end
      if (i == 2) check_val("exact_start_pulse", int'(o_start), 0);
      if (i == 5) check_val("exact_len_err_hold", int'(o_len_err), 1);
    end
    check_val("exact_cnt_live", int'(o_beat_cnt), 8);
    check_val("exact_no_done", int'(o_done), 0);
    drive(1'b0, 0);
    check_val("exact_done", int'(o_done), 1);
    check_val("exact_len_err", int'(o_len_err), 0);
    check_val("exact_cnt", int'(o_beat_cnt), 8);
    check_val("exact_sum", int'(o_sum), esum(36));
    drive(1'b0, 0);
    check_val("exact_done_pulse", int'(o_done), 0);
    check_val("exact_sum_hold", int'(o_sum), esum(36));

    // overrun: 12 x 0x01
    for (int i = 1; i <= 12; i++) begin
      drive(1'b1, 1);
      check_val($sformatf("ovr_busy%0d", i), int'(o_busy), 1);
      check_val($sformatf("ovr_cnt%0d", i), int'(o_beat_cnt), (i > 8) ? 9 : i);
      if (i >= 8) check_val($sformatf("ovr_sum%0d", i), int'(o_sum), esum(8));
    end
    check_val("ovr_no_done", int'(o_done), 0);
    drive(1'b0, 0);
    check_val("ovr_done", int'(o_done), 1);
    check_val("ovr_len_err", int'(o_len_err), 1);
    check_val("ovr_cnt", int'(o_beat_cnt), 9);
    check_val("ovr_sum", int'(o_sum), esum(8));
    drive(1'b0, 0);

    // back-to-back: 1..8, one low cycle, 10..17
    for (int i = 1; i <= 8; i++) drive(1'b1, i);
    drive(1'b0, 0);
    check_val("b2b_done1", int'(o_done), 1);
    check_val("b2b_len_err1", int'(o_len_err), 0);
    check_val("b2b_sum1", int'(o_sum), esum(36));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 10 + i);
      if (i == 0) begin
        check_val("b2b_start2", int'(o_start), 1);
        check_val("b2b_done_gone", int'(o_done), 0);
        check_val("b2b_cnt_reload", int'(o_beat_cnt), 1);
        check_val("b2b_sum_reload", int'(o_sum), esum(10));
      end
    end
    drive(1'b0, 0);
    check_val("b2b_done2", int'(o_done), 1);
    check_val("b2b_len_err2", int'(o_len_err), 0);
    check_val("b2b_cnt2", int'(o_beat_cnt), 8);
    check_val("b2b_sum2", int'(o_sum), esum(108));
    drive(1'b0, 0);

    // reset on beat 4, then an 8-beat frame starting right after reset drops
    for (int i = 1; i <= 3; i++) drive(1'b1, 3);
    reset = 1'b1;
    drive(1'b1, 3);
    check_val("mrst_done", int'(o_done), 0);
    check_val("mrst_cnt", int'(o_beat_cnt), 0);
    check_val("mrst_sum", int'(o_sum), 0);
    check_val("mrst_busy", int'(o_busy), 0);
    check_val("mrst_start", int'(o_start), 0);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2);
      if (i == 1) begin
        check_val("mrst_new_start", int'(o_start), 1);
        check_val("mrst_new_cnt", int'(o_beat_cnt), 1);
        check_val("mrst_new_done", int'(o_done), 0);
      end
    end
    drive(1'b0, 0);
    check_val("mrst_frame_done", int'(o_done), 1);
    check_val("mrst_frame_len_err", int'(o_len_err), 0);
    check_val("mrst_frame_cnt", int'(o_beat_cnt), 8);
    check_val("mrst_frame_sum", int'(o_sum), esum(16));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/valid_rx.md
VALID_RX -- requirements
Module: valid_rx

Interface
REQ-001 Parameter FRAME_LEN, default 1000: expected number of valid beats per frame; minimum 2.
REQ-002 Parameter DW, default 8: width of i_data.
REQ-003 Port clk  input  1  sole clock; all logic on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port i_valid  input  1  frame window, high for each data beat.
REQ-006 Port i_data  input  DW  beat data, sampled when i_valid=1.
REQ-007 Port o_start  output  1  one-cycle pulse at frame start.
REQ-008 Port o_done  output  1  one-cycle pulse at frame end.
REQ-009 Port o_len_err  output  1  frame length mismatch flag, valid with o_done.
REQ-010 Port o_beat_cnt  output  clog2(FRAME_LEN+2)  beats counted in last/current frame.
REQ-011 Port o_sum  output  DW+clog2(FRAME_LEN)  unsigned sum of frame data.
REQ-012 Port o_busy  output  1  high while in ACTIVE or OVERRUN.

Function
REQ-013 Block SHALL be the receiving end of a stretched-valid window: collapse it to start/done pulses and check length.
REQ-014 FSM states SHALL be IDLE, ACTIVE, OVERRUN.
REQ-015 IDLE with i_valid=1 at cycle T SHALL: go ACTIVE, load cnt=1, sum=i_data, assert o_start at T+1 for exactly one cycle.
REQ-016 ACTIVE with i_valid=1 and cnt<FRAME_LEN SHALL: cnt+1, sum+i_data.
REQ-017 ACTIVE with i_valid=1 and cnt==FRAME_LEN SHALL: go OVERRUN, cnt=FRAME_LEN+1, sum unchanged.
REQ-018 OVERRUN SHALL ignore i_data and hold cnt at FRAME_LEN+1 (saturated) while i_valid=1.
REQ-019 ACTIVE or OVERRUN with i_valid=0 at cycle E SHALL: go IDLE, assert o_done at E+1 for one cycle, with o_len_err=1 iff final cnt != FRAME_LEN.
REQ-020 o_len_err SHALL update only on the o_done cycle and hold until next o_done or reset.
REQ-021 o_beat_cnt and o_sum SHALL track live values during the frame and hold final values in IDLE until the next frame start reloads them.
REQ-022 A single i_valid=0 cycle between frames SHALL suffice: end frame N and start frame N+1 on the next high cycle; o_done(N) and o_start(N+1) on consecutive cycles.
REQ-023 All outputs SHALL be registered; no combinational path input to output.
REQ-024 Sum arithmetic SHALL be unsigned, full width, no overflow at FRAME_LEN beats of all-ones data.

Reset
REQ-025 reset=1 SHALL force IDLE and all outputs to 0 at next clk edge, overriding any input.
REQ-026 Reset mid-frame SHALL abort the frame with no o_done; if i_valid=1 on the first cycle after reset deasserts, that cycle SHALL count as a new frame start.

Configuration
REQ-027 Macro VALID_RX_SUM_EN defined: sum accumulator and o_sum behave per REQ-011/015/016/021/024.
REQ-028 Macro VALID_RX_SUM_EN undefined: no accumulator logic; o_sum SHALL be constant 0; all other behaviour identical.

Verification (FRAME_LEN=8, DW=8, VALID_RX_SUM_EN defined unless stated)
REQ-029 Exact frame: i_valid high 8 cycles, data 1..8 -> o_start 1 cycle after first beat, o_done 1 cycle after valid falls, o_len_err=0, o_beat_cnt=8, o_sum=36.
REQ-030 Short frame: 5 beats of 0xFF -> o_done, o_len_err=1, o_beat_cnt=5, o_sum=1275.
REQ-031 Overrun: 12 beats of 0x01 -> o_busy throughout, o_beat_cnt saturates at 9, o_sum=8, o_len_err=1 on o_done.
REQ-032 Back-to-back: 8 beats, 1 low cycle, 8 beats -> two o_done pulses, both o_len_err=0, o_done and second o_start adjacent.
REQ-033 Reset mid-frame: reset at beat 4 -> no o_done, all outputs 0; following 8-beat frame completes with o_len_err=0.
REQ-034 VALID_RX_SUM_EN undefined: run REQ-029 -> identical pulses and count, o_sum=0.
